// File: rtl/rom_arbiter.sv
// Arbitrates the program ROM read port between instruction fetch and data operand reads.
// Data wins contention until STARVE_MAX consecutive data grants, then fetch is forced through.
module rom_arbiter #(
  parameter logic [15:0] BOUND_U    = 16'hFFFF,
  parameter logic [15:0] BOUND_L    = 16'hC000,
  parameter logic [3:0]  STARVE_MAX = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic [15:0] dm_addr,
  input  logic        dm_bw,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [15:0] dm_rdata,
  output logic        dm_err,
  output logic [15:0] rom_addr,
  output logic        rom_bw,
  input  logic [15:0] rom_out
);

  logic [3:0]  starve_cnt;
  logic        fetch_win;
  logic        data_win;
  logic        if_in;
  logic        dm_in;
  logic [15:0] if_idx;
  logic [15:0] dm_idx;
  logic [15:0] dm_word;

  // Upper bound compared zero-extended so a full-range BOUND_U stays well-formed.
  assign if_in  = (if_addr >= BOUND_L) && ({1'b0, if_addr} <= {1'b0, BOUND_U});
  assign dm_in  = (dm_addr >= BOUND_L) && ({1'b0, dm_addr} <= {1'b0, BOUND_U});
  assign if_idx = (if_addr - BOUND_L) >> 1;
  assign dm_idx = (dm_addr - BOUND_L) >> 1;

  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (rst_n) begin
      fetch_win = if_req && (!dm_req || (starve_cnt >= STARVE_MAX));
      data_win  = dm_req && !fetch_win;
    end
  end

  assign if_gnt = fetch_win;
  assign dm_gnt = data_win;

  always_comb begin
    rom_addr = '0;
    rom_bw   = 1'b0;
    if (fetch_win && if_in) begin
      rom_addr = if_idx;
    end else if (data_win && dm_in) begin
      rom_addr = dm_idx;
      rom_bw   = dm_bw & ~dm_addr[0];
    end
  end

  always_comb begin
    dm_word = rom_out;
    if (dm_bw) begin
      dm_word = dm_addr[0] ? {8'h00, rom_out[15:8]} : {8'h00, rom_out[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
    end else begin
      if (data_win && if_req) begin
        starve_cnt <= (starve_cnt >= STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
      if_valid <= fetch_win;
      dm_valid <= data_win;
      if (fetch_win) begin
        if_rdata <= if_in ? rom_out : '0;
        if_err   <= !if_in;
      end
      if (data_win) begin
        dm_rdata <= dm_in ? dm_word : '0;
        dm_err   <= !dm_in;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a 16-word behavioural ROM on the read port.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic [15:0] dm_addr;
  logic        dm_bw;
  logic        dm_gnt;
  logic        dm_valid;
  logic [15:0] dm_rdata;
  logic        dm_err;
  logic [15:0] rom_addr;
  logic        rom_bw;
  logic [15:0] rom_out;

  logic [15:0] mem [16];
  int unsigned errors = 0;
  int unsigned checks = 0;
  string       pattern;

  always #5 clk = ~clk;

  assign rom_out = rom_bw ? {8'h00, mem[rom_addr[3:0]][7:0]} : mem[rom_addr[3:0]];

  rom_arbiter #(
    .BOUND_U    (16'hFFFF),
    .BOUND_L    (16'hC000),
    .STARVE_MAX (4'd4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_bw    (dm_bw),
    .dm_gnt   (dm_gnt),
    .dm_valid (dm_valid),
    .dm_rdata (dm_rdata),
    .dm_err   (dm_err),
    .rom_addr (rom_addr),
    .rom_bw   (rom_bw),
    .rom_out  (rom_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia,
                       input logic dr, input logic [15:0] da, input logic db);
    if_req  = ir;
    if_addr = ia;
    dm_req  = dr;
    dm_addr = da;
    dm_bw   = db;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'hABCD;
    mem[1]  = 16'h1234;
    mem[2]  = 16'h4031;
    mem[3]  = 16'h5678;
    mem[15] = 16'hBEEF;

    // Reset held 3 cycles with both requests asserted
    rst_n = 1'b0;
    drive(1'b1, 16'hC004, 1'b1, 16'hC000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_if_gnt", 16'(if_gnt), 16'd0);
      check("rst_dm_gnt", 16'(dm_gnt), 16'd0);
      check("rst_if_valid", 16'(if_valid), 16'd0);
      check("rst_dm_valid", 16'(dm_valid), 16'd0);
      check("rst_if_rdata", if_rdata, 16'h0000);
      check("rst_dm_rdata", dm_rdata, 16'h0000);
      check("rst_rom_addr", rom_addr, 16'h0000);
      check("rst_rom_bw", 16'(rom_bw), 16'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_dm_gnt", 16'(dm_gnt), 16'd1);
    check("rel_if_gnt", 16'(if_gnt), 16'd0);
    step();
    check("rel_dm_valid", 16'(dm_valid), 16'd1);
    check("rel_dm_rdata", dm_rdata, 16'hABCD);
    check("rel_if_valid", 16'(if_valid), 16'd0);

    // Word fetch, bit 0 ignored on the second access
    drive(1'b1, 16'hC004, 1'b0, 16'hC000, 1'b0);
    check("wf_if_gnt", 16'(if_gnt), 16'd1);
    check("wf_dm_gnt", 16'(dm_gnt), 16'd0);
    check("wf_rom_addr", rom_addr, 16'h0002);
    step();
    check("wf_if_valid", 16'(if_valid), 16'd1);
    check("wf_if_rdata", if_rdata, 16'h4031);
    check("wf_if_err", 16'(if_err), 16'd0);
    check("wf_dm_valid", 16'(dm_valid), 16'd0);
    drive(1'b1, 16'hC007, 1'b0, 16'hC000, 1'b0);
    check("wf_odd_rom_addr", rom_addr, 16'h0003);
    step();
    check("wf_b2b_valid", 16'(if_valid), 16'd1);
    check("wf_odd_rdata", if_rdata, 16'h5678);

    // Byte reads of word 0
    drive(1'b0, 16'hC004, 1'b1, 16'hC001, 1'b1);
    check("bo_dm_gnt", 16'(dm_gnt), 16'd1);
    check("bo_rom_addr", rom_addr, 16'h0000);
    check("bo_rom_bw", 16'(rom_bw), 16'd0);
    step();
    check("bo_dm_valid", 16'(dm_valid), 16'd1);
    check("bo_dm_rdata", dm_rdata, 16'h00AB);
    check("bo_if_valid", 16'(if_valid), 16'd0);
    drive(1'b0, 16'hC004, 1'b1, 16'hC000, 1'b1);
    check("be_rom_bw", 16'(rom_bw), 16'd1);
    step();
    check("be_dm_valid", 16'(dm_valid), 16'd1);
    check("be_dm_rdata", dm_rdata, 16'h00CD);

    // Out of range, then back in range
    drive(1'b0, 16'hC004, 1'b1, 16'h0200, 1'b0);
    check("oor_dm_gnt", 16'(dm_gnt), 16'd1);
    check("oor_rom_addr", rom_addr, 16'h0000);
    check("oor_rom_bw", 16'(rom_bw), 16'd0);
    step();
    check("oor_dm_valid", 16'(dm_valid), 16'd1);
    check("oor_dm_err", 16'(dm_err), 16'd1);
    check("oor_dm_rdata", dm_rdata, 16'h0000);
    drive(1'b0, 16'hC004, 1'b1, 16'hC002, 1'b0);
    step();
    check("ir_dm_err", 16'(dm_err), 16'd0);
    check("ir_dm_rdata", dm_rdata, 16'h1234);

    // Range edges: just below BOUND_L and at BOUND_U
    drive(1'b1, 16'hBFFF, 1'b0, 16'hC000, 1'b0);
    check("lo_rom_addr", rom_addr, 16'h0000);
    step();
    check("lo_if_err", 16'(if_err), 16'd1);
    check("lo_if_rdata", if_rdata, 16'h0000);
    drive(1'b0, 16'hC004, 1'b1, 16'hFFFF, 1'b0);
    check("hi_rom_addr", rom_addr, 16'h1FFF);
    step();
    check("hi_dm_err", 16'(dm_err), 16'd0);
    check("hi_dm_rdata", dm_rdata, 16'hBEEF);

    // Idle: no grants, responses hold
    drive(1'b0, 16'hC004, 1'b0, 16'hC000, 1'b0);
    check("idle_if_gnt", 16'(if_gnt), 16'd0);
    check("idle_dm_gnt", 16'(dm_gnt), 16'd0);
    step();
    check("idle_dm_valid", 16'(dm_valid), 16'd0);
    check("idle_if_valid", 16'(if_valid), 16'd0);
    check("idle_dm_hold", dm_rdata, 16'hBEEF);
    check("idle_if_hold", if_rdata, 16'h0000);

    // Continuous contention: D,D,D,D,F repeating
    pattern = "DDDDFDDDDF";
    drive(1'b1, 16'hC004, 1'b1, 16'hC006, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stv_if_gnt%0d", i), 16'(if_gnt), 16'(pattern[i] == "F"));
      check($sformatf("stv_dm_gnt%0d", i), 16'(dm_gnt), 16'(pattern[i] == "D"));
      step();
    end

    // Two data grants build the counter, then reset lands on a third grant
    step();
    step();
    check("mid_dm_gnt", 16'(dm_gnt), 16'd1);
    rst_n = 1'b0;
    step();
    check("mid_dm_valid", 16'(dm_valid), 16'd0);
    check("mid_if_valid", 16'(if_valid), 16'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("post_if_gnt%0d", i), 16'(if_gnt), 16'(pattern[i] == "F"));
      check($sformatf("post_dm_gnt%0d", i), 16'(dm_gnt), 16'(pattern[i] == "D"));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single read port of the program ROM between the CPU instruction-fetch unit and the data-memory operand path. Each cycle it selects one requester, translates its 16-bit byte address into the ROM word index, and drives the ROM's asynchronous read port. It registers the returned word or byte and presents it to the winner one cycle later. Operand reads normally win, with a starvation counter that guarantees fetch forward progress.

## Interface
- BOUND_U, 16'hFFFF, highest byte address mapped to ROM
- BOUND_L, 16'hC000, lowest byte address mapped to ROM
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (1..15)

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous and active-low
- if_req  in  1  fetch request; word read
- if_addr  in  16  fetch byte address; bit 0 ignored
- if_gnt  out  1  fetch selected this cycle (combinational)
- if_valid  out  1  fetch response valid (registered, 1-cycle pulse)
- if_rdata  out  16  fetch response word
- if_err  out  1  fetch address out of range (qualifies if_valid)
- dm_req  in  1  data read request
- dm_addr  in  16  data byte address
- dm_bw  in  1  1 = byte read, 0 = word read (bit 0 of address ignored)
- dm_gnt, dm_valid, dm_rdata[15:0], dm_err  out  as fetch equivalents
- rom_addr  out  16  ROM word index
- rom_bw  out  1  ROM byte-select (low byte only)
- rom_out  in  16  ROM read data, combinational from rom_addr/rom_bw

## Operation
- Range check per request: in range iff BOUND_L <= addr <= BOUND_U. Word index = (addr - BOUND_L) >> 1, 16-bit unsigned, zero-extended onto rom_addr.
- Arbitration, evaluated every cycle with rst_n high:
  - only one req: that requester wins
  - both req, starve_cnt < STARVE_MAX: data wins, starve_cnt increments
  - both req, starve_cnt == STARVE_MAX: fetch wins, starve_cnt clears
  - any cycle fetch wins, or if_req is low: starve_cnt clears
- starve_cnt is 4 bits and saturates at STARVE_MAX.
- Exactly one gnt high per cycle with any req; none with no req. Losing requester holds req/addr and retries; requests are not queued.
- ROM drive:
  - winner's index on rom_addr
  - rom_bw = dm_bw & ~dm_addr[0] when data wins, else 0
  - no winner or out-of-range: rom_addr = 0, rom_bw = 0
- Response capture at the clock edge ending the grant cycle:
  - word: rdata = rom_out
  - even byte: rdata = {8'h00, rom_out[7:0]}
  - odd byte: rdata = {8'h00, rom_out[15:8]}
  - out of range: rdata = 16'h0000, err = 1, valid = 1; ROM is not accessed
- Response registers hold their last value when valid is low. err is meaningful only with valid.
- No backpressure: requesters must accept valid in the cycle it is asserted.

## Timing
- Reset (rst_n low at an edge): if_valid, dm_valid, if_err, dm_err = 0; if_rdata, dm_rdata = 0; starve_cnt = 0. While rst_n is low, if_gnt = dm_gnt = 0, rom_addr = 0, rom_bw = 0.
- Latency: grant in cycle N, valid/rdata/err in cycle N+1 only. Throughput is one read per cycle across both ports.
- A grant in the last cycle before reset asserts produces no response; valid stays 0 through reset.
- First grant is possible in the first cycle with rst_n high.
- Back-to-back grants to the same port give consecutive valid pulses.

## Test plan
- Reset: hold rst_n low 3 cycles with both req high. Expect both gnt = 0, both valid = 0, rdata = 0. Release rst_n: dm_gnt = 1 in the first cycle.
- Word fetch: if_req, if_addr = 16'hC004, ROM word[2] = 16'h4031. Expect if_gnt in cycle N, rom_addr = 2, then if_valid and if_rdata = 16'h4031 in N+1.
- Byte reads at word[0] = 16'hABCD: dm_bw = 1, dm_addr = 16'hC001 gives dm_rdata = 16'h00AB with rom_bw = 0. dm_addr = 16'hC000 gives 16'h00CD with rom_bw = 1.
- Starvation, STARVE_MAX = 4: both req held continuously. Expect grant sequence D,D,D,D,F,D,D,D,D,F…
- Out of range: dm_addr = 16'h0200. Expect dm_gnt = 1, rom_addr = 0, then dm_valid = 1, dm_err = 1, dm_rdata = 0. Next in-range read returns dm_err = 0.
- Reset mid-grant: dm granted at cycle N, rst_n low at the N edge. Expect dm_valid = 0 at N+1 and starve_cnt = 0, checked via the next contention giving 4 data grants before fetch.
